// File: rtl/pc_flow_if.sv
// pc_flow_if: request/response bundle between the main control FSM, the
// vector memory port and the PC flow controller (pc_flow_ctrl).
// The master modport is the environment side; the slave modport is the
// controller.
interface pc_flow_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] flow_op;
    logic       alu_zero;
    logic       alu_gt;
    logic       exc_overflow;
    logic       exc_divzero;
    logic       mem_ready;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       mem_rd;
    logic [7:0] vec_addr;
    logic [1:0] exc_cause;
    logic       done;
    logic       fault;

    modport master (
        output req_valid, flow_op, alu_zero, alu_gt, exc_overflow, exc_divzero, mem_ready,
        input  req_ready, pc_source, pc_write, epc_write, mem_rd, vec_addr, exc_cause, done, fault
    );

    modport slave (
        input  req_valid, flow_op, alu_zero, alu_gt, exc_overflow, exc_divzero, mem_ready,
        output req_ready, pc_source, pc_write, epc_write, mem_rd, vec_addr, exc_cause, done, fault
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: drives the PC source selector and PC/EPC write strobes.
// Resolves sequential/branch/jump/rte flow per instruction and runs the
// multi-cycle exception entry (EPC save, vector byte fetch, PC load).
// All outputs are registered: the action of a state appears on the outputs
// in the cycle after that state, which gives the two-cycle accept-to-write
// latency and keeps req_ready low in the cycle that carries done.
// Optional build macro: PC_FLOW_CTRL_WATCHDOG_EN adds a fetch watchdog that
// sets a sticky fault flag when the vector byte never arrives.
module pc_flow_ctrl #(
    parameter logic [7:0] VEC_OPCODE   = 8'd253,
    parameter logic [7:0] VEC_OVERFLOW = 8'd254,
    parameter logic [7:0] VEC_DIVZERO  = 8'd255,
    parameter int         MEM_TIMEOUT  = 16
) (
    input  logic     clk,
    input  logic     reset,
    pc_flow_if.slave bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EVAL      = 3'd1;
    localparam logic [2:0] ST_EXC_SAVE  = 3'd2;
    localparam logic [2:0] ST_EXC_FETCH = 3'd3;
    localparam logic [2:0] ST_EXC_LOAD  = 3'd4;

    logic [2:0] state_r, state_s;
    logic [2:0] op_r;
    logic       zero_r, gt_r, ovf_r, dz_r;
    logic       capture_s;
    logic       req_ready_r, req_ready_s;
    logic [2:0] pc_source_r, pc_source_s;
    logic       pc_write_r, pc_write_s;
    logic       epc_write_r, epc_write_s;
    logic       mem_rd_r, mem_rd_s;
    logic [7:0] vec_addr_r, vec_addr_s;
    logic [1:0] exc_cause_r, exc_cause_s;
    logic       done_r, done_s;
    logic       fault_r, fault_s;

`ifdef PC_FLOW_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_r, wd_cnt_s;
`endif

    // Map a non-exception flow op and its captured flags to a mux select.
    function automatic logic [2:0] flow_select(input logic [2:0] op, input logic zero,
                                               input logic gt);
        logic [2:0] sel;
        case (op)
            3'b000:  sel = 3'd0;
            3'b001:  sel = zero ? 3'd1 : 3'd0;
            3'b010:  sel = zero ? 3'd0 : 3'd1;
            3'b011:  sel = gt   ? 3'd1 : 3'd0;
            3'b100:  sel = gt   ? 3'd0 : 3'd1;
            3'b101:  sel = 3'd2;
            3'b110:  sel = 3'd4;
            default: sel = 3'd0;
        endcase
        return sel;
    endfunction

    // Next-state and next-output decode for the flow controller.
    always_comb begin
        state_s     = state_r;
        capture_s   = 1'b0;
        pc_source_s = pc_source_r;
        pc_write_s  = 1'b0;
        epc_write_s = 1'b0;
        mem_rd_s    = mem_rd_r;
        vec_addr_s  = vec_addr_r;
        exc_cause_s = exc_cause_r;
        done_s      = 1'b0;
        fault_s     = fault_r;
`ifdef PC_FLOW_CTRL_WATCHDOG_EN
        wd_cnt_s    = wd_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    capture_s   = 1'b1;
                    exc_cause_s = 2'b00;
                    state_s     = ST_EVAL;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (op_r == 3'b111) begin
                    exc_cause_s = 2'b01;
                    vec_addr_s  = VEC_OPCODE;
                    state_s     = ST_EXC_SAVE;
                end else if (ovf_r) begin
                    exc_cause_s = 2'b10;
                    vec_addr_s  = VEC_OVERFLOW;
                    state_s     = ST_EXC_SAVE;
                end else if (dz_r) begin
                    exc_cause_s = 2'b11;
                    vec_addr_s  = VEC_DIVZERO;
                    state_s     = ST_EXC_SAVE;
                end else begin
                    pc_source_s = flow_select(op_r, zero_r, gt_r);
                    pc_write_s  = 1'b1;
                    done_s      = 1'b1;
                    state_s     = ST_IDLE;
                end
            end
            ST_EXC_SAVE: begin
                epc_write_s = 1'b1;
                mem_rd_s    = 1'b1;
`ifdef PC_FLOW_CTRL_WATCHDOG_EN
                wd_cnt_s    = '0;
`endif
                state_s     = ST_EXC_FETCH;
            end
            ST_EXC_FETCH: begin
                if (bus.mem_ready) begin
                    mem_rd_s = 1'b0;
                    state_s  = ST_EXC_LOAD;
`ifdef PC_FLOW_CTRL_WATCHDOG_EN
                end else if (wd_cnt_r == WD_W'(MEM_TIMEOUT - 1)) begin
                    // Byte never arrived: give up without touching the PC.
                    fault_s  = 1'b1;
                    mem_rd_s = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    wd_cnt_s = wd_cnt_r + WD_W'(1);
                    state_s  = ST_EXC_FETCH;
                end
`else
                end else begin
                    state_s  = ST_EXC_FETCH;
                end
`endif
            end
            ST_EXC_LOAD: begin
                pc_source_s = 3'd3;
                pc_write_s  = 1'b1;
                done_s      = 1'b1;
                mem_rd_s    = 1'b0;
                state_s     = ST_IDLE;
            end
            default: begin
                mem_rd_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
        // Ready only in IDLE, and not in the cycle that carries done.
        req_ready_s = (state_s == ST_IDLE) && !done_s;
    end

    // State, captured request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 3'd0;
            zero_r      <= 1'b0;
            gt_r        <= 1'b0;
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
            req_ready_r <= 1'b1;
            pc_source_r <= 3'd0;
            pc_write_r  <= 1'b0;
            epc_write_r <= 1'b0;
            mem_rd_r    <= 1'b0;
            vec_addr_r  <= 8'd0;
            exc_cause_r <= 2'b00;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
`ifdef PC_FLOW_CTRL_WATCHDOG_EN
            wd_cnt_r    <= '0;
`endif
        end else begin
            state_r     <= state_s;
            req_ready_r <= req_ready_s;
            pc_source_r <= pc_source_s;
            pc_write_r  <= pc_write_s;
            epc_write_r <= epc_write_s;
            mem_rd_r    <= mem_rd_s;
            vec_addr_r  <= vec_addr_s;
            exc_cause_r <= exc_cause_s;
            done_r      <= done_s;
            fault_r     <= fault_s;
`ifdef PC_FLOW_CTRL_WATCHDOG_EN
            wd_cnt_r    <= wd_cnt_s;
`endif
            if (capture_s) begin
                op_r   <= bus.flow_op;
                zero_r <= bus.alu_zero;
                gt_r   <= bus.alu_gt;
                ovf_r  <= bus.exc_overflow;
                dz_r   <= bus.exc_divzero;
            end else begin
                op_r   <= op_r;
                zero_r <= zero_r;
                gt_r   <= gt_r;
                ovf_r  <= ovf_r;
                dz_r   <= dz_r;
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.pc_source = pc_source_r;
    assign bus.pc_write  = pc_write_r;
    assign bus.epc_write = epc_write_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.vec_addr  = vec_addr_r;
    assign bus.exc_cause = exc_cause_r;
    assign bus.done      = done_r;
    assign bus.fault     = fault_r;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb_pc_flow_ctrl: table-driven and randomized checks of pc_flow_ctrl
// against a transaction-level reference model, plus reset/stall sequences.
module tb_pc_flow_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_flow_if bus ();

    pc_flow_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0] last_src = 3'd0;

    typedef struct {
        logic [2:0] op;
        logic       zero, gt, ovf, dz;
        int         delay;
    } req_t;

    typedef struct {
        logic [2:0] src;
        logic [1:0] cause;
        logic [7:0] vec;
        bit         exc;
    } exp_t;

    typedef struct {
        req_t r;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(input logic [2:0] op, input logic z, input logic g,
                                    input logic o, input logic d, input int delay);
        req_t r;
        r.op = op; r.zero = z; r.gt = g; r.ovf = o; r.dz = d; r.delay = delay;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] src, input logic [1:0] cause,
                                    input logic [7:0] vec, input bit exc);
        exp_t e;
        e.src = src; e.cause = cause; e.vec = vec; e.exc = exc;
        return e;
    endfunction

    // Reference model: outcome of one instruction's flow decision.
    function automatic exp_t model(input req_t r);
        bit taken;
        if (r.op == 3'd7)  return mk_exp(3'd3, 2'd1, 8'd253, 1'b1);
        if (r.ovf)         return mk_exp(3'd3, 2'd2, 8'd254, 1'b1);
        if (r.dz)          return mk_exp(3'd3, 2'd3, 8'd255, 1'b1);
        taken = (r.op == 3'd1 && r.zero) || (r.op == 3'd2 && !r.zero) ||
                (r.op == 3'd3 && r.gt)   || (r.op == 3'd4 && !r.gt);
        if (r.op == 3'd5)  return mk_exp(3'd2, 2'd0, 8'd0, 1'b0);
        if (r.op == 3'd6)  return mk_exp(3'd4, 2'd0, 8'd0, 1'b0);
        return mk_exp(taken ? 3'd1 : 3'd0, 2'd0, 8'd0, 1'b0);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".pc_source"}, bus.pc_source, 0);
        chk({tag, ".pc_write"},  bus.pc_write, 0);
        chk({tag, ".epc_write"}, bus.epc_write, 0);
        chk({tag, ".mem_rd"},    bus.mem_rd, 0);
        chk({tag, ".vec_addr"},  bus.vec_addr, 0);
        chk({tag, ".exc_cause"}, bus.exc_cause, 0);
        chk({tag, ".done"},      bus.done, 0);
        chk({tag, ".fault"},     bus.fault, 0);
        chk({tag, ".req_ready"}, bus.req_ready, 1);
    endtask

    // Present a request when ready and return at the first negedge after accept.
    task automatic issue(input string tag, input req_t r);
        for (int w = 0; w < 10 && !bus.req_ready; w++) @(negedge clk);
        chk({tag, ".ready_wait"}, bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.flow_op      = r.op;
        bus.alu_zero     = r.zero;
        bus.alu_gt       = r.gt;
        bus.exc_overflow = r.ovf;
        bus.exc_divzero  = r.dz;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.flow_op      = 3'($urandom);
        bus.alu_zero     = 1'($urandom);
        bus.alu_gt       = 1'($urandom);
        bus.exc_overflow = 1'($urandom);
        bus.exc_divzero  = 1'($urandom);
    endtask

    // One full transaction observed cycle by cycle (k=1 is the EVAL cycle).
    task automatic run_txn(input string tag, input req_t r, input exp_t e);
        int pw_cnt = 0, pw_k = -1, epc_cnt = 0, epc_k = -1, done_cnt = 0, done_k = -1;
        int done_bad = 0, mr_cnt = 0;
        logic [2:0] src_seen = 3'd0;
        logic [7:0] vec_seen = 8'd0;
        logic rdy_after = 1'b0;
        issue(tag, r);
        chk({tag, ".ready_eval"}, bus.req_ready, 0);
        chk({tag, ".cause_clr"},  bus.exc_cause, 0);
        chk({tag, ".src_hold"},   bus.pc_source, last_src);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.pc_write)  begin pw_cnt++;  pw_k = k; src_seen = bus.pc_source; end
            if (bus.epc_write) begin epc_cnt++; epc_k = k; end
            if (bus.done)      begin done_cnt++; done_k = k; end
            if (bus.done !== bus.pc_write) done_bad++;
            if (bus.mem_rd)    begin mr_cnt++; vec_seen = bus.vec_addr; end
            if (bus.mem_rd) bus.mem_ready = (mr_cnt == r.delay);
            else            bus.mem_ready = 1'($urandom);
            if (done_k > 0 && k == done_k + 1) begin
                rdy_after = bus.req_ready;
                break;
            end
        end
        bus.mem_ready = 1'b0;
        chk({tag, ".pw_cnt"},   pw_cnt, 1);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".done_pw"},  done_bad, 0);
        chk({tag, ".pw_cycle"}, pw_k, e.exc ? 4 + r.delay : 2);
        chk({tag, ".pc_src"},   src_seen, e.src);
        chk({tag, ".epc_cnt"},  epc_cnt, e.exc ? 1 : 0);
        chk({tag, ".mem_rd_n"}, mr_cnt, e.exc ? r.delay : 0);
        chk({tag, ".cause"},    bus.exc_cause, e.cause);
        chk({tag, ".rdy_after"}, rdy_after, 1);
        if (e.exc) begin
            chk({tag, ".epc_cycle"}, epc_k, 3);
            chk({tag, ".vec"},       vec_seen, e.vec);
        end
        last_src = e.src;
    endtask

    vec_t tbl[13];

    initial begin
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.flow_op = 3'd0; bus.alu_zero = 1'b0; bus.alu_gt = 1'b0;
        bus.exc_overflow = 1'b0; bus.exc_divzero = 1'b0; bus.mem_ready = 1'b0;

        tbl[0]  = '{mk_req(3'd1, 1, 0, 0, 0, 1), mk_exp(3'd1, 2'd0, 8'd0, 0)};
        tbl[1]  = '{mk_req(3'd1, 0, 1, 0, 0, 1), mk_exp(3'd0, 2'd0, 8'd0, 0)};
        tbl[2]  = '{mk_req(3'd5, 0, 0, 0, 0, 1), mk_exp(3'd2, 2'd0, 8'd0, 0)};
        tbl[3]  = '{mk_req(3'd6, 1, 1, 0, 0, 1), mk_exp(3'd4, 2'd0, 8'd0, 0)};
        tbl[4]  = '{mk_req(3'd2, 0, 0, 0, 0, 1), mk_exp(3'd1, 2'd0, 8'd0, 0)};
        tbl[5]  = '{mk_req(3'd2, 1, 0, 0, 0, 1), mk_exp(3'd0, 2'd0, 8'd0, 0)};
        tbl[6]  = '{mk_req(3'd3, 0, 1, 0, 0, 1), mk_exp(3'd1, 2'd0, 8'd0, 0)};
        tbl[7]  = '{mk_req(3'd4, 0, 1, 0, 0, 1), mk_exp(3'd0, 2'd0, 8'd0, 0)};
        tbl[8]  = '{mk_req(3'd4, 1, 0, 0, 0, 1), mk_exp(3'd1, 2'd0, 8'd0, 0)};
        tbl[9]  = '{mk_req(3'd0, 1, 1, 0, 0, 1), mk_exp(3'd0, 2'd0, 8'd0, 0)};
        tbl[10] = '{mk_req(3'd0, 0, 0, 1, 1, 5), mk_exp(3'd3, 2'd2, 8'd254, 1)};
        tbl[11] = '{mk_req(3'd7, 0, 0, 0, 1, 2), mk_exp(3'd3, 2'd1, 8'd253, 1)};
        tbl[12] = '{mk_req(3'd3, 0, 0, 0, 1, 1), mk_exp(3'd3, 2'd3, 8'd255, 1)};

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int i = 0; i < 13; i++) run_txn($sformatf("tbl%0d", i), tbl[i].r, tbl[i].e);

        for (int i = 0; i < 40; i++) begin
            req_t r;
            r = mk_req(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                       $urandom_range(1, 8));
            run_txn($sformatf("rnd%0d", i), r, model(r));
        end

        // Reset while waiting for the vector byte abandons the sequence.
        begin
            int pw = 0;
            issue("rstfetch", mk_req(3'd7, 0, 0, 0, 0, 1));
            for (int w = 0; w < 10 && !bus.mem_rd; w++) @(negedge clk);
            chk("rstfetch.mem_rd_on", bus.mem_rd, 1);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check_reset_outputs("rstfetch");
            reset = 1'b1;
            bus.mem_ready = 1'b1;
            repeat (4) begin @(negedge clk); if (bus.pc_write) pw++; end
            bus.mem_ready = 1'b0;
            chk("rstfetch.no_pw", pw, 0);
            last_src = 3'd0;
        end

        // Vector byte that never arrives.
        begin
            int pw = 0, dn = 0, mr = 0;
            issue("stall", mk_req(3'd0, 0, 0, 1, 0, 1));
            for (int w = 0; w < 10 && !bus.mem_rd; w++) @(negedge clk);
            for (int k = 0; k < 30; k++) begin
                if (bus.mem_rd) mr++;
                if (bus.pc_write) pw++;
                if (bus.done) dn++;
                @(negedge clk);
            end
            chk("stall.no_pw", pw, 0);
            chk("stall.no_done", dn, 0);
`ifdef PC_FLOW_CTRL_WATCHDOG_EN
            chk("stall.mem_rd_cycles", mr, 16);
            chk("stall.fault", bus.fault, 1);
            chk("stall.idle_ready", bus.req_ready, 1);
            chk("stall.mem_rd_off", bus.mem_rd, 0);
`else
            chk("stall.mem_rd_cycles", mr, 30);
            chk("stall.mem_rd_held", bus.mem_rd, 1);
            chk("stall.fault", bus.fault, 0);
            chk("stall.ready_low", bus.req_ready, 0);
`endif
            reset = 1'b0;
            @(negedge clk);
            check_reset_outputs("stall_rst");
            reset = 1'b1;
            last_src = 3'd0;
        end

        run_txn("post", mk_req(3'd5, 0, 0, 0, 0, 1), mk_exp(3'd2, 2'd0, 8'd0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
